i2c_txn_sequencer: RTL and testbench
====================================

# i2c_txn_sequencer

Register-transaction sequencer and arbiter in front of the byte-level I2C master. Accepts single-register write and read requests from `NUM_REQ` requesters and grants them round-robin. It expands each granted request into a START / byte / repeated-START / STOP command stream for the master core, then returns read data and ACK status to the winning requester. It sits between the system-side register clients and the I2C master, and is the only driver of the master's command port.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `TIMEOUT_CYC`, 100000: max `clk` cycles spent waiting for one `m_done`. Width is `$clog2(TIMEOUT_CYC+1)`.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request pending. Held until `req_ready`.
- `req_ready`  out  NUM_REQ  one-hot accept strobe, 1 cycle.
- `req_rw`  in  NUM_REQ  1 = register read, 0 = register write.
- `req_dev_addr`  in  7*NUM_REQ  packed 7-bit device addresses; requester i uses bits [7i+6:7i].
- `req_reg`  in  8*NUM_REQ  packed register index.
- `req_wdata`  in  8*NUM_REQ  packed write data. Ignored for reads.
- `rsp_valid`  out  NUM_REQ  one-hot completion strobe, 1 cycle.
- `rsp_rdata`  out  8  read byte. Valid with `rsp_valid`; 0 for writes.
- `rsp_err`  out  2  0 = OK, 1 = NACK, 2 = timeout.
- `m_cmd_valid`  out  1  command to master valid.
- `m_cmd_ready`  in  1  master accepts command.
- `m_cmd`  out  2  0 = START, 1 = WRITE, 2 = READ, 3 = STOP.
- `m_tx_data`  out  8  byte for WRITE.
- `m_rd_last`  out  1  for READ: 1 = master returns NACK.
- `m_done`  in  1  1-cycle pulse; command finished on the bus.
- `m_rx_data`  in  8  byte from READ. Valid with `m_done`.
- `m_ack_in`  in  1  slave ACK bit after WRITE (0 = ACK). Valid with `m_done`.

## Operation
- FSM states: `IDLE`, `START`, `ADDR_W`, `REG`, `DATA`, `RSTART`, `ADDR_R`, `READ`, `STOP`, `RESP`. Every command state has two phases:
  - ISSUE: `m_cmd_valid` = 1 until `m_cmd_ready`.
  - WAIT: until `m_done` or timeout.
- Write request: START → ADDR_W (`{dev,0}`) → REG (`reg`) → DATA (`wdata`) → STOP → RESP.
- Read request: START → ADDR_W (`{dev,0}`) → REG (`reg`) → RSTART (a START command) → ADDR_R (`{dev,1}`) → READ (`m_rd_last` = 1) → STOP → RESP.
- Any WRITE completing with `m_ack_in` = 1: latch `rsp_err` = 1 and go directly to STOP. Remaining bytes are skipped.
- WAIT counter reaching `TIMEOUT_CYC`: latch `rsp_err` = 2 and go to RESP with no STOP issued. The timeout counter clears on every state entry.
- On `m_done` in READ: latch `rsp_rdata` from `m_rx_data`.
- Arbitration, in `IDLE`: grant the lowest index ≥ `rr_ptr` with `req_valid` set, wrapping modulo `NUM_REQ`. `req_ready[g]` is combinational in that cycle. Request fields are captured on the same edge. Then `rr_ptr` ← g+1 (wrap) and state → START.
- RESP: `rsp_valid[g]` = 1 for one cycle, then IDLE.
- At most one transaction in flight. Requests arriving during a transaction wait.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `m_cmd_valid` = 0, `m_cmd` = 0, `m_tx_data` = 0, `m_rd_last` = 0, `rr_ptr` = 0, state = IDLE.
- Reset asserted mid-transaction: abandon immediately with no STOP and no `rsp_valid`. The master is reset by the same `rst`.
- Accept latency: `req_valid` high in IDLE → `req_ready` in the same cycle → `m_cmd_valid` (START) in the next cycle.
- `m_cmd` and `m_tx_data` are registered and stable while `m_cmd_valid` is high. `m_cmd_valid` drops in the cycle after the ready handshake.
- `m_done` arriving in the same cycle as the handshake is ignored. The master guarantees `m_done` comes at least 1 cycle later.
- `m_done` while not in WAIT: ignored.
- Back-to-back requests: completion cycle (RESP) → IDLE → the next grant takes ≥1 idle cycle between transactions.

## Structure
- `i2c_pkg`: `i2c_cmd_t` enum (START/WRITE/READ/STOP), `i2c_err_t` enum (OK/NACK/TIMEOUT), sequencer `state_t` enum. Shared with the master core.
- Sub-module `i2c_rr_arbiter` (NUM_REQ, clk, rst, `req`, `advance` → `grant` one-hot, `rr_ptr` register).
- Top: FSM, issue/wait flag, timeout counter, request capture registers.

## Test plan
- Write req0: dev 0x50, reg 0x10, data 0xA5, all ACK.
  - Command stream: START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, STOP.
  - Response: `rsp_valid[0]`, `rsp_err` = 0, `rsp_rdata` = 0.
- Read req1: dev 0x50, reg 0x22, master returns 0x3C.
  - Command stream: START, WRITE 0xA0, WRITE 0x22, START, WRITE 0xA1, READ (`m_rd_last` = 1), STOP.
  - Response: `rsp_rdata` = 0x3C, `rsp_err` = 0.
- `m_ack_in` = 1 on the address byte: next command is STOP; `rsp_err` = 1; no REG byte issued.
- Both requesters valid continuously from reset:
  - Grants alternate 0,1,0,1.
  - `rsp_valid` one-hot matches the grant order.
- Master never pulses `m_done` after START (`TIMEOUT_CYC` = 50):
  - `rsp_valid` 51–53 cycles after the START handshake, with `rsp_err` = 2.
- `rst` pulsed during DATA WAIT:
  - All outputs return to reset values asynchronously; no `rsp_valid`.
  - Next grant goes to requester 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: command, error and sequencer state types shared by the sequencer and the master core
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } i2c_err_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR_W,
        ST_REG,
        ST_DATA,
        ST_RSTART,
        ST_ADDR_R,
        ST_READ,
        ST_STOP,
        ST_RESP
    } state_t;

    // States that drive a command to the master core
    function automatic logic is_cmd_state(state_t s);
        return !(s == ST_IDLE || s == ST_RESP);
    endfunction

    // States whose command is a WRITE byte and therefore carry an ACK bit
    function automatic logic is_write_state(state_t s);
        return s == ST_ADDR_W || s == ST_REG || s == ST_DATA || s == ST_ADDR_R;
    endfunction

    // Master command issued from a given sequencer state
    function automatic i2c_cmd_t cmd_of(state_t s);
        return (s == ST_START || s == ST_RSTART) ? CMD_START :
               (s == ST_READ) ? CMD_READ :
               (s == ST_STOP) ? CMD_STOP : CMD_WRITE;
    endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: requester handshake plus master-core command port
interface i2c_txn_sequencer_if
    import i2c_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_dev_addr;
    logic [8*NUM_REQ-1:0] req_reg;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [7:0]           rsp_rdata;
    i2c_err_t             rsp_err;
    logic                 m_cmd_valid;
    logic                 m_cmd_ready;
    i2c_cmd_t             m_cmd;
    logic [7:0]           m_tx_data;
    logic                 m_rd_last;
    logic                 m_done;
    logic [7:0]           m_rx_data;
    logic                 m_ack_in;

    modport master (
        input  req_valid, req_rw, req_dev_addr, req_reg, req_wdata,
        input  m_cmd_ready, m_done, m_rx_data, m_ack_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_cmd_valid, m_cmd, m_tx_data, m_rd_last
    );

    modport slave (
        output req_valid, req_rw, req_dev_addr, req_reg, req_wdata,
        output m_cmd_ready, m_done, m_rx_data, m_ack_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_cmd_valid, m_cmd, m_tx_data, m_rd_last
    );
endinterface

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter: round-robin grant starting at rr_ptr, pointer moves past the winner on advance
module i2c_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ix;
    logic          found;

    // Scan from rr_ptr upward with wrap; first requester found wins
    always_comb begin
        grant = '0;
        gidx  = '0;
        ix    = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ix = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[ix]) begin
                found = 1'b1;
                gidx  = ix;
            end
        end
        grant[gidx] = found;
    end

    // Pointer lands one past the granted requester so it gets lowest priority next
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: arbitrates register requests and expands them into I2C master command streams
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input logic              clk,
    input logic              rst,
    i2c_txn_sequencer_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t             state, state_n, adv;
    logic               wait_q, wait_n;
    logic [CW-1:0]      cnt, cnt_n;
    i2c_err_t           err_q, err_n;
    logic [7:0]         rdata_q, rdata_n;
    logic               cmd_valid_q, cmd_valid_n;
    i2c_cmd_t           cmd_q, cmd_n;
    logic [7:0]         tx_q, tx_n;
    logic               rd_last_q, rd_last_n;
    logic [NUM_REQ-1:0] grant, gnt_q;
    logic [6:0]         dev_q;
    logic [7:0]         reg_q, wdata_q;
    logic               rw_q;
    logic               take;

    assign take = (state == ST_IDLE) && |bus.req_valid;

    i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (take),
        .grant   (grant)
    );

    assign bus.req_ready   = (state == ST_IDLE) ? grant : '0;
    assign bus.rsp_valid   = (state == ST_RESP) ? gnt_q : '0;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.m_cmd_valid = cmd_valid_q;
    assign bus.m_cmd       = cmd_q;
    assign bus.m_tx_data   = tx_q;
    assign bus.m_rd_last   = rd_last_q;

    // Successor of each command state on a clean completion
    assign adv = (state == ST_START)  ? ST_ADDR_W :
                 (state == ST_ADDR_W) ? ST_REG :
                 (state == ST_REG)    ? (rw_q ? ST_RSTART : ST_DATA) :
                 (state == ST_RSTART) ? ST_ADDR_R :
                 (state == ST_ADDR_R) ? ST_READ :
                 (state == ST_STOP)   ? ST_RESP : ST_STOP;

    // Next state, issue/wait phase, timeout count and the registered command outputs
    always_comb begin
        state_n   = state;
        wait_n    = wait_q;
        cnt_n     = cnt;
        err_n     = err_q;
        rdata_n   = rdata_q;
        cmd_n     = cmd_q;
        tx_n      = tx_q;
        rd_last_n = rd_last_q;
        if (state == ST_IDLE) begin
            if (take) begin
                state_n = ST_START;
                wait_n  = 1'b0;
                cnt_n   = '0;
                err_n   = ERR_OK;
                rdata_n = '0;
            end
        end else if (state == ST_RESP) begin
            state_n = ST_IDLE;
        end else if (!wait_q) begin
            wait_n = bus.m_cmd_ready;
        end else if (bus.m_done) begin
            wait_n  = 1'b0;
            cnt_n   = '0;
            state_n = (is_write_state(state) && bus.m_ack_in) ? ST_STOP : adv;
            err_n   = (is_write_state(state) && bus.m_ack_in) ? ERR_NACK : err_q;
            rdata_n = (state == ST_READ) ? bus.m_rx_data : rdata_q;
        end else if (cnt == CW'(TIMEOUT_CYC)) begin
            wait_n  = 1'b0;
            cnt_n   = '0;
            state_n = ST_RESP;
            err_n   = ERR_TIMEOUT;
        end else begin
            cnt_n = cnt + 1'b1;
        end
        cmd_valid_n = is_cmd_state(state_n) && !wait_n;
        if (is_cmd_state(state_n)) begin
            cmd_n     = cmd_of(state_n);
            rd_last_n = state_n == ST_READ;
            tx_n      = (state_n == ST_ADDR_W) ? {dev_q, 1'b0} :
                        (state_n == ST_ADDR_R) ? {dev_q, 1'b1} :
                        (state_n == ST_REG)    ? reg_q :
                        (state_n == ST_DATA)   ? wdata_q : 8'h00;
        end
    end

    // FSM and output registers; reset abandons any transaction without a STOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_q      <= 1'b0;
            cnt         <= '0;
            err_q       <= ERR_OK;
            rdata_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_START;
            tx_q        <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            state       <= state_n;
            wait_q      <= wait_n;
            cnt         <= cnt_n;
            err_q       <= err_n;
            rdata_q     <= rdata_n;
            cmd_valid_q <= cmd_valid_n;
            cmd_q       <= cmd_n;
            tx_q        <= tx_n;
            rd_last_q   <= rd_last_n;
        end
    end

    // Capture the granted requester's fields on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q   <= '0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
        end else if (take) begin
            gnt_q <= grant;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    dev_q   <= bus.req_dev_addr[7*i +: 7];
                    reg_q   <= bus.req_reg[8*i +: 8];
                    wdata_q <= bus.req_wdata[8*i +: 8];
                    rw_q    <= bus.req_rw[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed vector table plus hand-written corner sequences against a small master model
module tb_i2c_txn_sequencer;
    import i2c_pkg::*;

    localparam int NR = 2;
    localparam int TO = 50;
    localparam logic [9:0] S_ = 10'h000;
    localparam logic [9:0] R_ = 10'h200;
    localparam logic [9:0] P_ = 10'h300;
    localparam logic [9:0] Z_ = 10'h000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    i2c_txn_sequencer_if #(.NUM_REQ(NR)) bus ();

    i2c_txn_sequencer #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [7:0] rx;
        int         nack;
        logic [7:0] erd;
        logic [1:0] eerr;
        int         n;
        logic [6:0][9:0] s;
    } vec_t;

    vec_t vecs[6];
    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] log_q[$];
    int   hang_at = -1;
    int   nack_at = -1;
    int   wr_cnt  = 0;
    int   last_ix = 0;
    logic last_wr = 1'b0;
    logic pend    = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [9:0] w(input logic [7:0] b);
        return {2'b01, b};
    endfunction

    task automatic set_vec(input int i, input int idx, input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] rx,
                           input int nack, input logic [7:0] erd, input logic [1:0] eerr, input int n,
                           input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                           input logic [9:0] e3, input logic [9:0] e4, input logic [9:0] e5,
                           input logic [9:0] e6);
        vecs[i].idx = idx; vecs[i].rw = rw; vecs[i].dev = dev; vecs[i].rg = rg;
        vecs[i].wd = wd; vecs[i].rx = rx; vecs[i].nack = nack; vecs[i].erd = erd;
        vecs[i].eerr = eerr; vecs[i].n = n;
        vecs[i].s[0] = e0; vecs[i].s[1] = e1; vecs[i].s[2] = e2; vecs[i].s[3] = e3;
        vecs[i].s[4] = e4; vecs[i].s[5] = e5; vecs[i].s[6] = e6;
    endtask

    task automatic load_req(input int idx, input logic rw, input logic [6:0] dev,
                            input logic [7:0] rg, input logic [7:0] wd);
        bus.req_rw[idx] = rw;
        bus.req_dev_addr[7*idx +: 7] = dev;
        bus.req_reg[8*idx +: 8] = rg;
        bus.req_wdata[8*idx +: 8] = wd;
    endtask

    task automatic wait_rsp(output logic ok, output int k);
        ok = 1'b0;
        k = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            k++;
            ok = |bus.rsp_valid;
        end
    endtask

    // Master model: always ready, pulses m_done one cycle after each accepted command
    initial begin
        bus.m_cmd_ready = 1'b1;
        bus.m_done = 1'b0;
        bus.m_rx_data = 8'h00;
        bus.m_ack_in = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_done = 1'b0;
            bus.m_ack_in = 1'b0;
            if (pend) begin
                pend = 1'b0;
                if (last_ix != hang_at) begin
                    bus.m_done = 1'b1;
                    bus.m_rx_data = rx_byte;
                    bus.m_ack_in = last_wr && (wr_cnt == nack_at);
                    if (last_wr) wr_cnt++;
                end
            end else if (bus.m_cmd_valid && !rst) begin
                log_q.push_back({bus.m_cmd, bus.m_rd_last, bus.m_tx_data});
                last_ix = log_q.size() - 1;
                last_wr = bus.m_cmd == CMD_WRITE;
                pend = 1'b1;
            end
        end
    end

    task automatic run_vec(input int vi);
        vec_t v;
        logic [NR-1:0] oh;
        logic ok;
        int k;
        logic [10:0] e;
        v = vecs[vi];
        oh = '0;
        oh[v.idx] = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_rsp_one_cycle", vi), bus.rsp_valid, 0);
        log_q.delete();
        wr_cnt = 0; nack_at = v.nack; rx_byte = v.rx; hang_at = -1;
        load_req(v.idx, v.rw, v.dev, v.rg, v.wd);
        bus.req_valid = oh;
        #1 check($sformatf("v%0d_req_ready", vi), bus.req_ready, oh);
        @(negedge clk);
        check($sformatf("v%0d_start_next_cycle", vi), {bus.m_cmd_valid, bus.m_cmd}, {1'b1, CMD_START});
        bus.req_valid = '0;
        wait_rsp(ok, k);
        check($sformatf("v%0d_rsp_seen", vi), ok, 1);
        check($sformatf("v%0d_rsp_valid", vi), bus.rsp_valid, oh);
        check($sformatf("v%0d_rsp_rdata", vi), bus.rsp_rdata, v.erd);
        check($sformatf("v%0d_rsp_err", vi), bus.rsp_err, v.eerr);
        check($sformatf("v%0d_stream_len", vi), log_q.size(), v.n);
        for (int i = 0; i < v.n && i < log_q.size(); i++) begin
            e = log_q[i];
            check($sformatf("v%0d_cmd%0d", vi, i), e[10:9], v.s[i][9:8]);
            if (v.s[i][9:8] == 2'b01)
                check($sformatf("v%0d_byte%0d", vi, i), e[7:0], v.s[i][7:0]);
            if (v.s[i][9:8] == 2'b10)
                check($sformatf("v%0d_rd_last%0d", vi, i), e[8], 1);
        end
    endtask

    task automatic run_alt();
        logic [NR-1:0] g[4];
        logic [NR-1:0] r[4];
        int ng;
        int nr;
        ng = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin g[i] = '0; r[i] = '0; end
        log_q.delete(); nack_at = -1; hang_at = -1; rx_byte = 8'h00;
        load_req(0, 1'b0, 7'h10, 8'h01, 8'h02);
        load_req(1, 1'b0, 7'h20, 8'h03, 8'h04);
        @(negedge clk);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 400 && nr < 4; c++) begin
            #1;
            if (bus.req_ready != 0 && ng < 4) begin g[ng] = bus.req_ready; ng++; end
            if (bus.rsp_valid != 0) begin
                r[nr] = bus.rsp_valid;
                nr++;
                if (nr == 4) bus.req_valid = '0;
            end
            if (nr < 4) @(negedge clk);
        end
        check("alt_rsp_count", nr, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt_grant%0d", i), g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("alt_rsp%0d", i), r[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
    endtask

    task automatic run_timeout();
        logic ok;
        int k;
        @(negedge clk);
        log_q.delete(); wr_cnt = 0; nack_at = -1; hang_at = 0;
        load_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = '0;
        check("to_start_handshake", {bus.m_cmd_valid, bus.m_cmd}, {1'b1, CMD_START});
        wait_rsp(ok, k);
        check("to_rsp_seen", ok, 1);
        check($sformatf("to_latency_%0d_in_51_53", k), (k >= 51 && k <= 53), 1);
        check("to_rsp_valid", bus.rsp_valid, 2'b01);
        check("to_rsp_err", bus.rsp_err, ERR_TIMEOUT);
        check("to_no_stop", log_q.size(), 1);
        hang_at = -1;
    endtask

    task automatic run_rst();
        logic ok;
        int k;
        int seen;
        @(negedge clk);
        log_q.delete(); wr_cnt = 0; nack_at = -1; hang_at = 3;
        load_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = '0;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = (log_q.size() == 4) && !bus.m_cmd_valid;
        end
        check("rst_reached_data_wait", ok, 1);
        check("rst_tx_before", bus.m_tx_data, 8'hA5);
        #2 rst = 1'b1;
        #1;
        check("rst_async_cmd_valid", bus.m_cmd_valid, 0);
        check("rst_async_cmd", bus.m_cmd, 0);
        check("rst_async_tx", bus.m_tx_data, 0);
        check("rst_async_rd_last", bus.m_rd_last, 0);
        check("rst_async_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, 0);
        check("rst_async_ready", bus.req_ready, 0);
        @(negedge clk);
        rst = 1'b0; pend = 1'b0; hang_at = -1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0 || bus.m_cmd_valid) seen++;
        end
        check("rst_no_rsp_no_stop", seen, 0);
        check("rst_log_unchanged", log_q.size(), 4);
        load_req(1, 1'b0, 7'h20, 8'h03, 8'h04);
        bus.req_valid = 2'b11;
        #1 check("rst_next_grant_req0", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(ok, k);
        check("rst_after_rsp", bus.rsp_valid, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_rw = '0;
        bus.req_dev_addr = '0;
        bus.req_reg = '0;
        bus.req_wdata = '0;
        set_vec(0, 0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 8'h00, 2'd0, 5,
                S_, w(8'hA0), w(8'h10), w(8'hA5), P_, Z_, Z_);
        set_vec(1, 1, 1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, 8'h3C, 2'd0, 7,
                S_, w(8'hA0), w(8'h22), S_, w(8'hA1), R_, P_);
        set_vec(2, 0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 8'h00, 2'd1, 3,
                S_, w(8'hA0), P_, Z_, Z_, Z_, Z_);
        set_vec(3, 1, 1'b1, 7'h3A, 8'h05, 8'h00, 8'h81, -1, 8'h81, 2'd0, 7,
                S_, w(8'h74), w(8'h05), S_, w(8'h75), R_, P_);
        set_vec(4, 1, 1'b1, 7'h11, 8'h7F, 8'h00, 8'h99, 2, 8'h00, 2'd1, 6,
                S_, w(8'h22), w(8'h7F), S_, w(8'h23), P_, Z_);
        set_vec(5, 0, 1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, 2, 8'h00, 2'd1, 5,
                S_, w(8'hFE), w(8'hFF), w(8'h00), P_, Z_, Z_);
        repeat (3) @(negedge clk);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_cmd_valid", bus.m_cmd_valid, 0);
        check("reset_cmd", bus.m_cmd, 0);
        check("reset_tx_data", bus.m_tx_data, 0);
        check("reset_rd_last", bus.m_rd_last, 0);
        rst = 1'b0;
        run_alt();
        for (int i = 0; i < 6; i++) run_vec(i);
        run_timeout();
        run_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
